// File: rtl/ariane_axi_soc.sv
// rtl/ariane_axi_soc.sv - AXI4 channel and request/response struct types for the SoC fabric
package ariane_axi_soc;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [UserWidth-1:0] user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [2:0] prot;
        user_t      user;
    } aw_chan_t;

    typedef aw_chan_t ar_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/iommu_pkg.sv
// rtl/iommu_pkg.sv - shared register offsets, AXI response codes and FSM state types
package iommu_pkg;

    localparam logic [11:0] SETEIPNUM_OFF = 12'h000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        AW_IDLE,
        W_DATA,
        B_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading/trailing zero counter; MODE 0 counts trailing zeros
module lzc #(
    parameter int WIDTH     = 2,
    parameter bit MODE      = 1'b0,
    parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Later loop iterations overwrite earlier ones, so scan order picks the winning bit.
    always_comb begin
        cnt_o = '0;
        if (!MODE) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/iommu_msi_rx.sv
// rtl/iommu_msi_rx.sv - MSI interrupt file: AXI seteipnum writes set pending bits, claim clears top id
module iommu_msi_rx
    import iommu_pkg::*;
#(
    parameter int unsigned NUM_IDS   = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  ariane_axi_soc::req_t       mem_req_i,
    output ariane_axi_soc::resp_t      mem_resp_o,
    input  logic [NUM_IDS-1:0]         eie_i,
    input  logic                       claim_i,
    output logic [$clog2(NUM_IDS)-1:0] topid_o,
    output logic                       irq_o
);

    localparam int unsigned IDW = $clog2(NUM_IDS);

    wr_state_e               wr_state_q;
    ariane_axi_soc::id_t     aw_id_q;
    logic [63:0]             aw_addr_q;
    logic [7:0]              aw_len_q;
    logic [1:0]              b_resp_q;

    rd_state_e               rd_state_q;
    ariane_axi_soc::id_t     ar_id_q;
    logic [7:0]              ar_len_q;
    logic [7:0]              r_cnt_q;

    logic [NUM_IDS-1:0]      eip_q;
    logic [NUM_IDS-1:0]      eip_d;
    logic [NUM_IDS-1:0]      set_mask;
    logic [NUM_IDS-1:0]      clr_mask;
    logic [NUM_IDS-1:0]      lzc_in;
    logic [IDW-1:0]          lzc_cnt;
    logic                    lzc_empty;

    logic                    wr_ok;
    logic                    w_last_hs;
    logic [31:0]             wr_ident;
    logic                    unused_bits;

    assign wr_ok = (aw_addr_q[63:12] == BASE_ADDR[63:12]) &&
                   (aw_addr_q[11:2] == SETEIPNUM_OFF[11:2]) &&
                   (aw_len_q == 8'd0);
    assign w_last_hs = (wr_state_q == W_DATA) && mem_req_i.w_valid && mem_req_i.w.last;
    assign wr_ident  = aw_addr_q[2] ? mem_req_i.w.data[63:32] : mem_req_i.w.data[31:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= AW_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                AW_IDLE: begin
                    if (mem_req_i.aw_valid) begin
                        aw_id_q    <= mem_req_i.aw.id;
                        aw_addr_q  <= mem_req_i.aw.addr;
                        aw_len_q   <= mem_req_i.aw.len;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_last_hs) begin
                        b_resp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        wr_state_q <= B_RESP;
                    end
                end
                B_RESP: begin
                    if (mem_req_i.b_ready) wr_state_q <= AW_IDLE;
                end
                default: wr_state_q <= AW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            r_cnt_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (mem_req_i.ar_valid) begin
                        ar_id_q    <= mem_req_i.ar.id;
                        ar_len_q   <= mem_req_i.ar.len;
                        r_cnt_q    <= '0;
                        rd_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (mem_req_i.r_ready) begin
                        if (r_cnt_q == ar_len_q) rd_state_q <= R_IDLE;
                        else                     r_cnt_q    <= r_cnt_q + 8'd1;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Set is applied after clear so a same-cycle set and claim of one identity leaves it pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (w_last_hs && wr_ok && (wr_ident != 32'd0) && (wr_ident < NUM_IDS)) begin
            set_mask[wr_ident[IDW-1:0]] = 1'b1;
        end
        if (claim_i && (topid_o != '0)) begin
            clr_mask[topid_o] = 1'b1;
        end
        eip_d    = (eip_q & ~clr_mask) | set_mask;
        eip_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) eip_q <= '0;
        else       eip_q <= eip_d;
    end

    assign lzc_in = eip_q & eie_i & ~NUM_IDS'(1);

    lzc #(
        .WIDTH (NUM_IDS),
        .MODE  (1'b0)
    ) u_lzc (
        .in_i    (lzc_in),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    assign topid_o = lzc_empty ? '0 : lzc_cnt;
    assign irq_o   = (topid_o != '0);

    always_comb begin
        mem_resp_o          = '0;
        mem_resp_o.aw_ready = (wr_state_q == AW_IDLE);
        mem_resp_o.w_ready  = (wr_state_q == W_DATA);
        mem_resp_o.b_valid  = (wr_state_q == B_RESP);
        mem_resp_o.b.id     = aw_id_q;
        mem_resp_o.b.resp   = b_resp_q;
        mem_resp_o.ar_ready = (rd_state_q == R_IDLE);
        mem_resp_o.r_valid  = (rd_state_q == R_RESP);
        mem_resp_o.r.id     = ar_id_q;
        mem_resp_o.r.resp   = RESP_SLVERR;
        mem_resp_o.r.last   = (r_cnt_q == ar_len_q);
    end

    assign unused_bits = ^{mem_req_i, aw_addr_q[1:0]};

endmodule

// File: tb/tb_iommu_msi_rx.sv
// tb/tb_iommu_msi_rx.sv - directed self-checking bench for iommu_msi_rx
module tb_iommu_msi_rx;

    localparam logic [63:0] BASE   = 64'h0000_0000_4000_0000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    ariane_axi_soc::req_t  req;
    ariane_axi_soc::resp_t rsp;
    logic [63:0]           eie;
    logic                  claim_i;
    logic [5:0]            topid;
    logic                  irq;

    int n_cmp = 0;
    int n_err = 0;
    logic seen_aw_ready;
    logic seen_w_ready;

    iommu_msi_rx #(
        .NUM_IDS   (64),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mem_req_i  (req),
        .mem_resp_o (rsp),
        .eie_i      (eie),
        .claim_i    (claim_i),
        .topid_o    (topid),
        .irq_o      (irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic axi_aw_w(input logic [63:0] addr, input logic [7:0] len,
                            input logic [63:0] data, input logic claim_on_last);
        req.aw.id     = 4'h3;
        req.aw.addr   = addr;
        req.aw.len    = len;
        req.aw_valid  = 1'b1;
        seen_aw_ready = rsp.aw_ready;
        tick();
        req.aw_valid  = 1'b0;
        seen_w_ready  = rsp.w_ready;
        req.w_valid   = 1'b1;
        req.w.data    = data;
        for (int i = 0; i <= int'(len); i++) begin
            req.w.last = (i == int'(len));
            claim_i    = (i == int'(len)) ? claim_on_last : 1'b0;
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        claim_i     = 1'b0;
    endtask

    task automatic b_ack();
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic claim_pulse();
        claim_i = 1'b1;
        tick();
        claim_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b want 0", irq); end
        n_cmp++; if (topid !== 6'd0) begin n_err++; $display("FAIL reset_topid: got %0d want 0", topid); end
        n_cmp++; if (rsp.aw_ready !== 1'b1) begin n_err++; $display("FAIL reset_aw_ready: got %0b want 1", rsp.aw_ready); end
        n_cmp++; if (rsp.ar_ready !== 1'b1) begin n_err++; $display("FAIL reset_ar_ready: got %0b want 1", rsp.ar_ready); end
        n_cmp++; if (rsp.w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %0b want 0", rsp.w_ready); end
        n_cmp++; if (rsp.b_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %0b want 0", rsp.b_valid); end
        n_cmp++; if (rsp.r_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_valid: got %0b want 0", rsp.r_valid); end
        n_cmp++; if (dut.eip_q !== 64'h0) begin n_err++; $display("FAIL reset_eip: got %0h want 0", dut.eip_q); end
    endtask

    task automatic test_single_write();
        axi_aw_w(BASE, 8'd0, 64'h5, 1'b0);
        n_cmp++; if (seen_aw_ready !== 1'b1) begin n_err++; $display("FAIL wr_aw_ready: got %0b want 1", seen_aw_ready); end
        n_cmp++; if (seen_w_ready !== 1'b1) begin n_err++; $display("FAIL wr_w_ready: got %0b want 1", seen_w_ready); end
        n_cmp++; if (rsp.b_valid !== 1'b1) begin n_err++; $display("FAIL wr_b_valid: got %0b want 1", rsp.b_valid); end
        n_cmp++; if (rsp.b.resp !== OKAY) begin n_err++; $display("FAIL wr_b_resp: got %0h want %0h", rsp.b.resp, OKAY); end
        n_cmp++; if (rsp.b.id !== 4'h3) begin n_err++; $display("FAIL wr_b_id: got %0h want 3", rsp.b.id); end
        n_cmp++; if (dut.eip_q !== 64'h20) begin n_err++; $display("FAIL wr_eip: got %0h want 20", dut.eip_q); end
        n_cmp++; if (topid !== 6'd5) begin n_err++; $display("FAIL wr_topid: got %0d want 5", topid); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL wr_irq: got %0b want 1", irq); end
        b_ack();
        n_cmp++; if (rsp.aw_ready !== 1'b1) begin n_err++; $display("FAIL wr_back_idle: got %0b want 1", rsp.aw_ready); end
        n_cmp++; if (rsp.b_valid !== 1'b0) begin n_err++; $display("FAIL wr_b_drop: got %0b want 0", rsp.b_valid); end
        claim_pulse();
        n_cmp++; if (topid !== 6'd0) begin n_err++; $display("FAIL wr_claim_topid: got %0d want 0", topid); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL wr_claim_irq: got %0b want 0", irq); end
    endtask

    task automatic test_priority();
        axi_aw_w(BASE, 8'd0, 64'h9, 1'b0);
        b_ack();
        axi_aw_w(BASE, 8'd0, 64'h3, 1'b0);
        b_ack();
        n_cmp++; if (dut.eip_q !== 64'h208) begin n_err++; $display("FAIL prio_eip: got %0h want 208", dut.eip_q); end
        n_cmp++; if (topid !== 6'd3) begin n_err++; $display("FAIL prio_first: got %0d want 3", topid); end
        claim_pulse();
        n_cmp++; if (topid !== 6'd9) begin n_err++; $display("FAIL prio_second: got %0d want 9", topid); end
        claim_pulse();
        n_cmp++; if (topid !== 6'd0) begin n_err++; $display("FAIL prio_empty: got %0d want 0", topid); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prio_irq: got %0b want 0", irq); end
    endtask

    task automatic test_errors();
        logic [63:0] addrs [6];
        logic [7:0]  lens  [6];
        logic [63:0] datas [6];
        logic [1:0]  resps [6];
        addrs = '{BASE + 64'h10, BASE, BASE + 64'h1000, BASE, BASE, BASE};
        lens  = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        datas = '{64'h6, 64'h6, 64'h6, 64'h0, 64'd64, 64'h0000_0005_0000_0000};
        resps = '{SLVERR, SLVERR, SLVERR, OKAY, OKAY, OKAY};
        for (int k = 0; k < 6; k++) begin
            axi_aw_w(addrs[k], lens[k], datas[k], 1'b0);
            n_cmp++; if (rsp.b.resp !== resps[k]) begin n_err++; $display("FAIL err_resp[%0d]: got %0h want %0h", k, rsp.b.resp, resps[k]); end
            n_cmp++; if (dut.eip_q !== 64'h0) begin n_err++; $display("FAIL err_eip[%0d]: got %0h want 0", k, dut.eip_q); end
            b_ack();
            n_cmp++; if (rsp.aw_ready !== 1'b1) begin n_err++; $display("FAIL err_idle[%0d]: got %0b want 1", k, rsp.aw_ready); end
        end
        axi_aw_w(BASE, 8'd0, 64'h5, 1'b0);
        b_ack();
        axi_aw_w(BASE, 8'd0, 64'h5, 1'b0);
        b_ack();
        claim_pulse();
        n_cmp++; if (dut.eip_q !== 64'h0) begin n_err++; $display("FAIL dup_no_count: got %0h want 0", dut.eip_q); end
    endtask

    task automatic test_mask();
        eie = ~(64'h1 << 7);
        axi_aw_w(BASE, 8'd0, 64'h7, 1'b0);
        b_ack();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_irq: got %0b want 0", irq); end
        n_cmp++; if (dut.eip_q !== 64'h80) begin n_err++; $display("FAIL mask_pending: got %0h want 80", dut.eip_q); end
        claim_pulse();
        n_cmp++; if (dut.eip_q !== 64'h80) begin n_err++; $display("FAIL mask_claim_ignored: got %0h want 80", dut.eip_q); end
        eie = '1;
        #1;
        n_cmp++; if (topid !== 6'd7) begin n_err++; $display("FAIL mask_enable_topid: got %0d want 7", topid); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mask_enable_irq: got %0b want 1", irq); end
        claim_pulse();
    endtask

    task automatic test_race();
        axi_aw_w(BASE, 8'd0, 64'h4, 1'b0);
        b_ack();
        n_cmp++; if (topid !== 6'd4) begin n_err++; $display("FAIL race_pre: got %0d want 4", topid); end
        axi_aw_w(BASE, 8'd0, 64'h4, 1'b1);
        n_cmp++; if (dut.eip_q !== 64'h10) begin n_err++; $display("FAIL race_set_wins: got %0h want 10", dut.eip_q); end
        b_ack();
        axi_aw_w(BASE, 8'd0, 64'h6, 1'b1);
        n_cmp++; if (dut.eip_q !== 64'h40) begin n_err++; $display("FAIL race_other_id: got %0h want 40", dut.eip_q); end
        n_cmp++; if (topid !== 6'd6) begin n_err++; $display("FAIL race_other_topid: got %0d want 6", topid); end
        b_ack();
        claim_pulse();
    endtask

    task automatic test_read();
        req.ar.id    = 4'h5;
        req.ar.addr  = BASE;
        req.ar.len   = 8'd0;
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        n_cmp++; if (rsp.r_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid: got %0b want 1", rsp.r_valid); end
        n_cmp++; if (rsp.ar_ready !== 1'b0) begin n_err++; $display("FAIL rd_ar_busy: got %0b want 0", rsp.ar_ready); end
        n_cmp++; if (rsp.r.id !== 4'h5) begin n_err++; $display("FAIL rd_id: got %0h want 5", rsp.r.id); end
        n_cmp++; if (rsp.r.resp !== SLVERR) begin n_err++; $display("FAIL rd_resp: got %0h want 2", rsp.r.resp); end
        n_cmp++; if (rsp.r.data !== 64'h0) begin n_err++; $display("FAIL rd_data: got %0h want 0", rsp.r.data); end
        n_cmp++; if (rsp.r.last !== 1'b1) begin n_err++; $display("FAIL rd_last: got %0b want 1", rsp.r.last); end
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        n_cmp++; if (rsp.r_valid !== 1'b0) begin n_err++; $display("FAIL rd_done: got %0b want 0", rsp.r_valid); end
        req.ar.len   = 8'd1;
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        tick();
        n_cmp++; if (rsp.r_valid !== 1'b1) begin n_err++; $display("FAIL rd_burst_beat2: got %0b want 1", rsp.r_valid); end
        tick();
        req.r_ready = 1'b0;
        n_cmp++; if (rsp.r_valid !== 1'b0) begin n_err++; $display("FAIL rd_burst_done: got %0b want 0", rsp.r_valid); end
        n_cmp++; if (rsp.ar_ready !== 1'b1) begin n_err++; $display("FAIL rd_burst_idle: got %0b want 1", rsp.ar_ready); end
    endtask

    task automatic test_reset_mid();
        axi_aw_w(BASE, 8'd0, 64'h5, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_cmp++; if (rsp.b_valid !== 1'b0) begin n_err++; $display("FAIL rstb_b_valid: got %0b want 0", rsp.b_valid); end
        n_cmp++; if (rsp.aw_ready !== 1'b1) begin n_err++; $display("FAIL rstb_aw_ready: got %0b want 1", rsp.aw_ready); end
        n_cmp++; if (dut.eip_q !== 64'h0) begin n_err++; $display("FAIL rstb_eip: got %0h want 0", dut.eip_q); end
        req.aw.addr  = BASE;
        req.aw.len   = 8'd0;
        req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        req.w.data   = 64'h9;
        rst_i        = 1'b1;
        tick();
        rst_i        = 1'b0;
        req.w_valid  = 1'b0;
        req.w.last   = 1'b0;
        n_cmp++; if (dut.eip_q !== 64'h0) begin n_err++; $display("FAIL rstw_eip: got %0h want 0", dut.eip_q); end
        n_cmp++; if (rsp.b_valid !== 1'b0) begin n_err++; $display("FAIL rstw_b_valid: got %0b want 0", rsp.b_valid); end
        n_cmp++; if (rsp.w_ready !== 1'b0) begin n_err++; $display("FAIL rstw_w_ready: got %0b want 0", rsp.w_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        req     = '0;
        eie     = '1;
        claim_i = 1'b0;
        rst_i   = 1'b1;
        test_reset();
        test_single_write();
        test_priority();
        test_errors();
        test_mask();
        test_race();
        test_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
